// File: rtl/axi_dw_upsizer_single.sv
// Single-beat AXI4 data-width upsizer: 32-bit narrow slave side to 512-bit wide master side.
// Lane offsets of outstanding writes and reads are held in two small FIFOs.

module axi_dw_upsizer_lane_fifo #(
  parameter int DEPTH = 4,
  parameter int LW    = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [LW-1:0] lane_i,
  input  logic          pop_i,
  output logic [LW-1:0] head_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [LW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= lane_i;
  end
endmodule

module axi_dw_upsizer_single #(
  parameter int NARROW_DW = 32,
  parameter int WIDE_DW   = 512,
  parameter int ADDR_W    = 64,
  parameter int ID_W      = 8,
  parameter int MAX_OUTST = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   s_aw_valid,
  output logic                   s_aw_ready,
  input  logic [ADDR_W-1:0]      s_aw_addr,
  input  logic [ID_W-1:0]        s_aw_id,
  input  logic [2:0]             s_aw_size,
  input  logic [7:0]             s_aw_len,
  input  logic                   s_w_valid,
  output logic                   s_w_ready,
  input  logic [NARROW_DW-1:0]   s_w_data,
  input  logic [NARROW_DW/8-1:0] s_w_strb,
  input  logic                   s_w_last,
  output logic                   s_b_valid,
  input  logic                   s_b_ready,
  output logic [ID_W-1:0]        s_b_id,
  output logic [1:0]             s_b_resp,
  input  logic                   s_ar_valid,
  output logic                   s_ar_ready,
  input  logic [ADDR_W-1:0]      s_ar_addr,
  input  logic [ID_W-1:0]        s_ar_id,
  input  logic [2:0]             s_ar_size,
  input  logic [7:0]             s_ar_len,
  output logic                   s_r_valid,
  input  logic                   s_r_ready,
  output logic [NARROW_DW-1:0]   s_r_data,
  output logic [ID_W-1:0]        s_r_id,
  output logic [1:0]             s_r_resp,
  output logic                   s_r_last,
  output logic                   m_aw_valid,
  input  logic                   m_aw_ready,
  output logic [ADDR_W-1:0]      m_aw_addr,
  output logic [ID_W-1:0]        m_aw_id,
  output logic [2:0]             m_aw_size,
  output logic [7:0]             m_aw_len,
  output logic                   m_w_valid,
  input  logic                   m_w_ready,
  output logic [WIDE_DW-1:0]     m_w_data,
  output logic [WIDE_DW/8-1:0]   m_w_strb,
  output logic                   m_w_last,
  input  logic                   m_b_valid,
  output logic                   m_b_ready,
  input  logic [ID_W-1:0]        m_b_id,
  input  logic [1:0]             m_b_resp,
  output logic                   m_ar_valid,
  input  logic                   m_ar_ready,
  output logic [ADDR_W-1:0]      m_ar_addr,
  output logic [ID_W-1:0]        m_ar_id,
  output logic [2:0]             m_ar_size,
  output logic [7:0]             m_ar_len,
  input  logic                   m_r_valid,
  output logic                   m_r_ready,
  input  logic [WIDE_DW-1:0]     m_r_data,
  input  logic [ID_W-1:0]        m_r_id,
  input  logic [1:0]             m_r_resp,
  input  logic                   m_r_last
);
  localparam int NB    = NARROW_DW / 8;
  localparam int LANES = WIDE_DW / NARROW_DW;
  localparam int LW    = $clog2(LANES);
  localparam int LO    = $clog2(NB);

  // Handshakes: a transfer happens on a rising clk_i edge where valid and ready
  // are both high; valid never depends on ready of the same channel.
  logic          w_full, w_empty, r_full, r_empty;
  logic [LW-1:0] w_head, r_head;
  logic          aw_hs, w_hs, ar_hs, r_hs;

  // Valids are forced low while reset is held, since the FIFO state is meaningless then.
  assign m_aw_valid = s_aw_valid & ~w_full & rst_ni;
  assign s_aw_ready = m_aw_ready & ~w_full;
  assign m_aw_addr  = s_aw_addr;
  assign m_aw_id    = s_aw_id;
  assign m_aw_size  = s_aw_size;
  assign m_aw_len   = s_aw_len;
  assign aw_hs      = s_aw_valid & s_aw_ready & rst_ni;

  assign m_w_valid  = s_w_valid & ~w_empty & rst_ni;
  assign s_w_ready  = m_w_ready & ~w_empty & rst_ni;
  assign m_w_data   = {LANES{s_w_data}};
  assign m_w_last   = s_w_last;
  assign w_hs       = s_w_valid & s_w_ready;

  always_comb begin
    m_w_strb = '0;
    m_w_strb[w_head*NB +: NB] = s_w_strb;
  end

  assign s_b_valid  = m_b_valid & rst_ni;
  assign m_b_ready  = s_b_ready;
  assign s_b_id     = m_b_id;
  assign s_b_resp   = m_b_resp;

  assign m_ar_valid = s_ar_valid & ~r_full & rst_ni;
  assign s_ar_ready = m_ar_ready & ~r_full;
  assign m_ar_addr  = s_ar_addr;
  assign m_ar_id    = s_ar_id;
  assign m_ar_size  = s_ar_size;
  assign m_ar_len   = s_ar_len;
  assign ar_hs      = s_ar_valid & s_ar_ready & rst_ni;

  assign s_r_valid  = m_r_valid & rst_ni;
  assign m_r_ready  = s_r_ready;
  assign s_r_id     = m_r_id;
  assign s_r_resp   = m_r_resp;
  assign s_r_last   = m_r_last;
  assign s_r_data   = r_empty ? '0 : m_r_data[r_head*NARROW_DW +: NARROW_DW];
  assign r_hs       = s_r_valid & s_r_ready;

  axi_dw_upsizer_lane_fifo #(.DEPTH(MAX_OUTST), .LW(LW)) u_wfifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (aw_hs),
    .lane_i  (s_aw_addr[LO+LW-1:LO]),
    .pop_i   (w_hs),
    .head_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  axi_dw_upsizer_lane_fifo #(.DEPTH(MAX_OUTST), .LW(LW)) u_rfifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (ar_hs),
    .lane_i  (s_ar_addr[LO+LW-1:LO]),
    .pop_i   (r_hs),
    .head_o  (r_head),
    .full_o  (r_full),
    .empty_o (r_empty)
  );

  // Only single-beat, at-most-narrow-width bursts are converted.
  a_aw_single: assert property (@(posedge clk_i) disable iff (!rst_ni)
    s_aw_valid |-> (s_aw_len == 8'd0 && s_aw_size <= 3'(LO)));
  a_ar_single: assert property (@(posedge clk_i) disable iff (!rst_ni)
    s_ar_valid |-> (s_ar_len == 8'd0 && s_ar_size <= 3'(LO)));
  a_r_tracked: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(m_r_valid && r_empty));
endmodule

// File: doc/axi_dw_upsizer_single.md
Name: axi_dw_upsizer_single

Overview:
- Sits directly downstream of the TL-UL-to-AXI bridge in the ddr4 subsystem, between it and the wide DDR4 controller AXI slave port.
- Converts single-beat narrow AXI4 transactions (32-bit) into single-beat wide AXI4 transactions (512-bit).
- Write data is lane-placed and strobe-shifted by address; read data is lane-selected by address.
- Per-transaction lane offsets are tracked in small FIFOs so that several reads and writes can be outstanding.

Parameters:
- NARROW_DW, 32, narrow (slave-side) data width in bits; power of 2.
- WIDE_DW, 512, wide (master-side) data width in bits; power of 2, a multiple of NARROW_DW.
- ADDR_W, 64, address width.
- ID_W, 8, AXI ID width.
- MAX_OUTST, 4, depth of each lane FIFO (read and write); power of 2, ≥1.
- Derived: NB = NARROW_DW/8; LANES = WIDE_DW/NARROW_DW; LW = log2(LANES); LO = log2(NB).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- s_aw_valid/s_aw_ready  in/out  1/1  narrow AW handshake
- s_aw_addr, s_aw_id, s_aw_size, s_aw_len  in  ADDR_W, ID_W, 3, 8  narrow AW payload
- s_w_valid/s_w_ready  in/out  1/1  narrow W handshake
- s_w_data, s_w_strb, s_w_last  in  NARROW_DW, NB, 1  narrow W payload
- s_b_valid/s_b_ready  out/in  1/1  narrow B handshake
- s_b_id, s_b_resp  out  ID_W, 2  narrow B payload
- s_ar_valid/s_ar_ready  in/out  1/1  narrow AR handshake
- s_ar_addr, s_ar_id, s_ar_size, s_ar_len  in  ADDR_W, ID_W, 3, 8  narrow AR payload
- s_r_valid/s_r_ready  out/in  1/1  narrow R handshake
- s_r_data, s_r_id, s_r_resp, s_r_last  out  NARROW_DW, ID_W, 2, 1  narrow R payload
- m_aw_*, m_w_*, m_b_*, m_ar_*, m_r_*  mirror of the s_* ports with direction reversed and data/strb widths WIDE_DW / WIDE_DW/8

Behaviour:
- Clock/reset: single clock clk_i; reset rst_ni is asynchronous, active-low. Reset clears both lane FIFOs (pointers and count to 0).
- Outputs during reset: m_aw_valid, m_w_valid, m_ar_valid, s_b_valid, s_r_valid = 0; s_w_ready = 0; s_r_valid = 0.
- Reset asserted mid-transaction discards all tracked lanes. The system resets the downstream slave together with this block.
- Lane extraction: lane = addr[LO+LW-1 : LO]. Address bits below LO are ignored for lane selection and passed through unchanged.
- AW path (combinational pass-through):
  - m_aw_valid = s_aw_valid & !wfifo_full.
  - s_aw_ready = m_aw_ready & !wfifo_full.
  - Payload is forwarded unchanged.
  - On AW handshake, the lane is pushed into wfifo.
- W path:
  - m_w_valid = s_w_valid & !wfifo_empty.
  - s_w_ready = m_w_ready & !wfifo_empty.
  - m_w_data = s_w_data replicated LANES times.
  - m_w_strb = s_w_strb << (head_lane*NB), with all other bits 0.
  - m_w_last = s_w_last.
  - On W handshake, wfifo pops.
  - There is no same-cycle AW-to-W bypass: a W arriving with its AW is accepted at the earliest one cycle after the AW handshake.
- AR path: m_ar_valid = s_ar_valid & !rfifo_full; s_ar_ready = m_ar_ready & !rfifo_full; payload forwarded unchanged. On AR handshake, the lane is pushed into rfifo.
- R path:
  - s_r_valid = m_r_valid; m_r_ready = s_r_ready.
  - s_r_data = m_r_data[head_lane*NARROW_DW +: NARROW_DW].
  - id, resp and last are forwarded.
  - On R handshake, rfifo pops.
  - m_r_valid while rfifo is empty is a protocol violation: the data returned is 0 and a simulation assertion fires.
- B path: pure pass-through; no lane state involved.
- FIFO rules:
  - When full, push is blocked even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full leaves the count unchanged.
  - Pointers wrap modulo MAX_OUTST.
  - FIFO output is registered-storage read at the head pointer; no added latency on R/W data.
- Limits:
  - len must be 0 (single beat).
  - size must be ≤ LO.
  - Violations are not converted; simulation assertions flag them.
- Latency: AW, AR, R and B have 0 cycles added (combinational). W has 0 cycles added when its AW handshake occurred in an earlier cycle.
- Ordering: AXI same-ID in-order return is relied upon. Responses must come back in request order (single ID stream from upstream).

Test Plan:
- Write at addr 0x1000_0024 with data 0xDEADBEEF and strb 0xF. Required: m_aw_addr 0x1000_0024; lane 9; m_w_strb = 0xF<<36; m_w_data[319:288] = 0xDEADBEEF; one B forwarded with the same id.
- Read at addr 0x1000_003C, with m_r_data lane 15 = 0x12345678 and all other lanes 0xFFFFFFFF. Required: s_r_data = 0x12345678, s_r_resp forwarded.
- AW and W presented in the same cycle with wfifo empty. Required: AW accepted in cycle 0; s_w_ready = 0 in cycle 0; W accepted in cycle 1.
- Issue 4 ARs (lanes 1, 2, 3, 4) with m_r_valid held 0. Required: the fifth AR sees s_ar_ready = 0. Then return 4 R beats; required: lanes 1, 2, 3, 4 are selected in order, and the fifth AR is accepted after the first R pop.
- AR push and R pop in the same cycle at count 2. Required: count stays 2 and the head lane advances correctly.
- Assert rst_ni low with 2 reads outstanding, then release. Required: all valids 0 during reset; FIFOs empty afterwards; a new read at lane 5 returns lane 5.
